// File: rtl/golden_nonce_queue.sv
// rtl/golden_nonce_queue.sv - golden nonce FIFO and serial_transmit handshake (optional GNQ_DROP_COUNT_EN)
module golden_nonce_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  hash_clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  found,
  input  logic [31:0]           nonce_in,
  input  logic                  exhausted,
  input  logic                  serial_busy,
  output logic                  serial_send,
  output logic [31:0]           word,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
`ifdef GNQ_DROP_COUNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_ACK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DEPTH_LOG2:0] wr_q, rd_q;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         word_q, word_d;
  logic                exh_flag_q, exh_flag_d;
  logic                exh_sent_q, exh_sent_d;   // a 0 word already went out this flush period
  logic [1:0]          tmo_q, tmo_d;
  logic                push, pop, send_zero;

  assign level       = wr_q - rd_q;
  assign full        = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  assign push        = found && !full && !flush;   // nonces arriving with flush belong to old work
  assign serial_send = (state_q == S_SEND);
  assign word        = word_q;

  // Transfer FSM: picks the next word (queued nonces before the exhausted marker) and tracks the UART handshake
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    tmo_d     = tmo_q;
    pop       = 1'b0;
    send_zero = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmo_d = 2'd0;
        if (!flush && !serial_busy) begin
          if (level != '0) begin
            pop     = 1'b1;
            word_d  = mem_q[rd_q[DEPTH_LOG2-1:0]];
            state_d = S_SEND;
          end else if (exh_flag_q) begin
            send_zero = 1'b1;
            word_d    = 32'h0;
            state_d   = S_SEND;
          end
        end
      end
      S_SEND: begin
        tmo_d   = 2'd0;
        state_d = S_ACK;
      end
      S_ACK: begin
        // a UART that never raises busy must not stall the queue: give up after 4 cycles
        if (serial_busy) begin
          state_d = S_DONE;
        end else if (tmo_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      S_DONE: begin
        if (!serial_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Exhausted marker: at most one 0 word between flushes
  always_comb begin
    exh_flag_d = exh_flag_q;
    exh_sent_d = exh_sent_q;
    if (flush) begin
      exh_flag_d = 1'b0;
      exh_sent_d = 1'b0;
    end else if (send_zero) begin
      exh_flag_d = 1'b0;
      exh_sent_d = 1'b1;
    end else if (exhausted && !exh_sent_q) begin
      exh_flag_d = 1'b1;
    end
  end

  // Control state, pointers and presented word
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      word_q     <= 32'h0;
      tmo_q      <= 2'd0;
      exh_flag_q <= 1'b0;
      exh_sent_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      tmo_q      <= tmo_d;
      exh_flag_q <= exh_flag_d;
      exh_sent_q <= exh_sent_d;
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers, so it needs no reset
  always_ff @(posedge hash_clk) begin
    if (push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= nonce_in;
  end

`ifdef GNQ_DROP_COUNT_EN
  logic [15:0] drop_q;
  assign drop_count = drop_q;

  // Saturating count of nonces lost to a full queue
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= 16'h0;
    end else if (flush) begin
      drop_q <= 16'h0;
    end else if (found && full && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_golden_nonce_queue.sv
// tb/tb_golden_nonce_queue.sv - directed self-checking bench for golden_nonce_queue
module tb_golden_nonce_queue;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        found;
  logic [31:0] nonce_in;
  logic        exhausted;
  logic        serial_busy;
  logic        serial_send;
  logic [31:0] word;
  logic [3:0]  level;
  logic        full;
`ifdef GNQ_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  logic        hold;
  logic        mute;
  logic [2:0]  ucnt;
  logic [31:0] sent [$];
  int          passed;
  int          total;

  golden_nonce_queue #(.DEPTH_LOG2(3)) dut (
    .hash_clk    (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .found       (found),
    .nonce_in    (nonce_in),
    .exhausted   (exhausted),
    .serial_busy (serial_busy),
    .serial_send (serial_send),
    .word        (word),
    .level       (level),
    .full        (full)
`ifdef GNQ_DROP_COUNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal UART stand-in: busy for 3 cycles after each send, word logged at the strobe
  always @(posedge clk) begin
    if (serial_send) begin
      sent.push_back(word);
      ucnt <= 3'd3;
    end else if (ucnt != 3'd0) begin
      ucnt <= ucnt - 3'd1;
    end
  end
  assign serial_busy = hold | (!mute && ucnt != 3'd0);

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] v);
    found    = 1'b1;
    nonce_in = v;
    tick(1);
    found    = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0;
    ucnt = 3'd0; hold = 1'b0; mute = 1'b0;
    reset_n = 1'b0; flush = 1'b0; found = 1'b0; nonce_in = 32'h0; exhausted = 1'b0;
    tick(3);
    check("rst_send",  32'(serial_send), 32'h0);
    check("rst_word",  word,             32'h0);
    check("rst_level", 32'(level),       32'h0);
    check("rst_full",  32'(full),        32'h0);
    reset_n = 1'b1;
    tick(2);

    // 1: single nonce, send strobe two cycles after found
    found = 1'b1; nonce_in = 32'h1234ABCD;
    tick(1);
    found = 1'b0;
    check("t1_level1", 32'(level),       32'h1);
    check("t1_nosend", 32'(serial_send), 32'h0);
    tick(1);
    check("t1_send",   32'(serial_send), 32'h1);
    check("t1_word",   word,             32'h1234ABCD);
    tick(1);
    check("t1_onecyc", 32'(serial_send), 32'h0);
    tick(20);
    check("t1_cnt",    32'(sent.size()), 32'h1);
    check("t1_val",    sent[0],          32'h1234ABCD);
    sent.delete();

    // ACK timeout: UART never raises busy, queue must still drain
    mute = 1'b1;
    push(32'h11111111);
    push(32'h22222222);
    tick(40);
    check("tmo_cnt",   32'(sent.size()), 32'h2);
    check("tmo_v0",    sent[0],          32'h11111111);
    check("tmo_v1",    sent[1],          32'h22222222);
    mute = 1'b0;
    sent.delete();

    // 2: three queued while busy (middle one is zero), sent in order
    hold = 1'b1;
    tick(1);
    push(32'hA0A0A0A0);
    push(32'h00000000);
    push(32'hC0C0C0C0);
    tick(2);
    check("t2_level",  32'(level),       32'h3);
    check("t2_held",   32'(sent.size()), 32'h0);
    hold = 1'b0;
    tick(40);
    check("t2_cnt",    32'(sent.size()), 32'h3);
    check("t2_a",      sent[0],          32'hA0A0A0A0);
    check("t2_b",      sent[1],          32'h00000000);
    check("t2_c",      sent[2],          32'hC0C0C0C0);
    check("t2_empty",  32'(level),       32'h0);
    sent.delete();

    // 3: overflow, 10 pushes into 8 slots
    hold = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
    check("t3_full",   32'(full),        32'h1);
    check("t3_level",  32'(level),       32'h8);
`ifdef GNQ_DROP_COUNT_EN
    check("t3_drops",  32'(drop_count),  32'h2);
`endif
    hold = 1'b0;
    tick(80);
    check("t3_cnt",    32'(sent.size()), 32'h8);
    check("t3_first",  sent[0],          32'h100);
    check("t3_last",   sent[7],          32'h107);
    check("t3_nfull",  32'(full),        32'h0);
    sent.delete();

    // 4: exhausted behind two queued nonces, repeat pulse ignored
    hold = 1'b1;
    tick(1);
    push(32'hAAAA0001);
    found = 1'b1; nonce_in = 32'hAAAA0002; exhausted = 1'b1;
    tick(1);
    found = 1'b0; exhausted = 1'b0;
    hold = 1'b0;
    tick(40);
    check("t4_cnt",    32'(sent.size()), 32'h3);
    check("t4_n0",     sent[0],          32'hAAAA0001);
    check("t4_n1",     sent[1],          32'hAAAA0002);
    check("t4_zero",   sent[2],          32'h0);
    sent.delete();
    exhausted = 1'b1;
    tick(1);
    exhausted = 1'b0;
    tick(30);
    check("t4_nozero2", 32'(sent.size()), 32'h0);

    // 5: flush with 5 queued while busy; same-cycle found discarded
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    push(32'h5A5A5A5A);
    tick(20);
    check("t5_pre",    32'(sent.size()), 32'h1);
    sent.delete();
    hold = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(i));
    check("t5_level5", 32'(level),       32'h5);
    flush = 1'b1; found = 1'b1; nonce_in = 32'h00000BAD;
    tick(1);
    flush = 1'b0; found = 1'b0;
    check("t5_level0", 32'(level),       32'h0);
    check("t5_word",   word,             32'h5A5A5A5A);
    hold = 1'b0;
    tick(30);
    check("t5_nosend", 32'(sent.size()), 32'h0);

    // 6: async reset while waiting in DONE
    push(32'hC0FFEE00);
    tick(1);
    check("t6_send",   32'(serial_send), 32'h1);
    hold = 1'b1;
    tick(2);
    push(32'h66666661);
    push(32'h66666662);
    tick(1);
    check("t6_level2", 32'(level),       32'h2);
    check("t6_word",   word,             32'hC0FFEE00);
    reset_n = 1'b0;
    #1;
    check("t6_rsend",  32'(serial_send), 32'h0);
    check("t6_rword",  word,             32'h0);
    check("t6_rlevel", 32'(level),       32'h0);
    check("t6_rfull",  32'(full),        32'h0);
    tick(2);
    sent.delete();
    reset_n = 1'b1;
    hold = 1'b0;
    tick(20);
    check("t6_idle",   32'(sent.size()), 32'h0);
    push(32'h00000077);
    tick(20);
    check("t6_resume", 32'(sent.size()), 32'h1);
    check("t6_rval",   sent[0],          32'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
